alu_seq: RTL

- Initiator side of the ALU micro-control interface. Accepts one 8-bit ALU request (function, operands A and B, carry-in) per handshake.
- Drives the three-cycle control-line sequence into the ALU:
  - load A,
  - load B and compute the low nibble,
  - compute the high nibble and output the result.
- Captures result and Z/N/H/C flags, then returns them through a valid/ready response port.
- Sits between the CPU decode/microcode stage and the ALU datapath.

---
 rtl/alu_seq_if.sv | 40 ++++
 rtl/alu_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if
//   Request/response bundle between the CPU decode/microcode stage and the
//   ALU micro-control sequencer.
//
//   Request  (master -> slave): req_valid, req_fn[2:0], req_a[7:0],
//                               req_b[7:0], req_cin
//   Request  (slave -> master): req_ready
//   Response (slave -> master): rsp_valid, rsp_result[7:0],
//                               rsp_z, rsp_n, rsp_h, rsp_c
//   Response (master -> slave): rsp_ready
//
//   master = the decode stage issuing operations, slave = alu_seq.
// ---------------------------------------------------------------------------
interface alu_seq_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_fn;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       req_cin;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_z;
    logic       rsp_n;
    logic       rsp_h;
    logic       rsp_c;

    modport master (
        output req_valid, req_fn, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_z, rsp_n, rsp_h, rsp_c
    );

    modport slave (
        input  req_valid, req_fn, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_z, rsp_n, rsp_h, rsp_c
    );
endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
//   Initiator side of the ALU micro-control interface. Accepts one 8-bit
//   request (function, A, B, carry-in), then drives the ALU through a
//   three-cycle control sequence:
//     LDA : load operand A
//     LO  : load operand B and compute the low nibble
//     HI  : compute the high nibble and enable the result onto the bus
//   The result and Z/N/H/C flags are returned on a valid/ready response.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   sif (slave)         request / response handshake bundle
//   alu_op[7:0]         operand bus into the ALU
//   alu_sh[1:0]         shifter control, always NO_SH
//   alu_oe[1:0]         output-enable select (SH_OE idle, RES_OE in HI)
//   alu_la, alu_lb      A/B latch load (BUS_LD / NO_LD)
//   alu_r/s/v/ne        function-select lines
//   alu_ci              carry-in
//   alu_l, alu_h        low/high nibble compute strobes
//   alu_result[7:0]     ALU result
//   alu_zero            ALU zero flag
//   alu_carry           ALU carry out (nibble carry in LO, byte carry in HI)
//
// Parameter
//   NO_BACKPRESSURE     1: rsp_ready ignored, DONE lasts exactly one cycle
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter bit NO_BACKPRESSURE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    alu_seq_if.slave   sif,
    output logic [7:0] alu_op,
    output logic [1:0] alu_sh,
    output logic [1:0] alu_oe,
    output logic       alu_la,
    output logic       alu_lb,
    output logic       alu_r,
    output logic       alu_s,
    output logic       alu_v,
    output logic       alu_ne,
    output logic       alu_ci,
    output logic       alu_l,
    output logic       alu_h,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_carry
);

    // ALU control encodings
    localparam logic [1:0] NO_SH  = 2'd0;
    localparam logic [1:0] SH_OE  = 2'd0;
    localparam logic [1:0] RES_OE = 2'd1;
    localparam logic       BUS_LD = 1'b1;
    localparam logic       NO_LD  = 1'b0;

    // Function codes
    localparam logic [2:0] FN_ADD = 3'd0;
    localparam logic [2:0] FN_ADC = 3'd1;
    localparam logic [2:0] FN_SUB = 3'd2;
    localparam logic [2:0] FN_SBC = 3'd3;
    localparam logic [2:0] FN_AND = 3'd4;
    localparam logic [2:0] FN_XOR = 3'd5;
    localparam logic [2:0] FN_OR  = 3'd6;
    localparam logic [2:0] FN_CP  = 3'd7;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LDA  = 3'd1,
        LO   = 3'd2,
        HI   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t     state_reg;
    logic [2:0] fn_reg;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic       cin_reg;
    logic       hc_reg;     // nibble carry sampled at the end of LO

    // Function-select lines {r, s, v, ne}. v enables the carry chain for
    // arithmetic; ne inverts B so subtraction is A + ~B + ci.
    function automatic logic [3:0] fsel(input logic [2:0] fn);
        logic [3:0] sel;
        sel = 4'b0000;
        case (fn)
            FN_ADD, FN_ADC:        sel = 4'b0010;
            FN_SUB, FN_SBC, FN_CP: sel = 4'b0011;
            FN_AND:                sel = 4'b0100;
            FN_XOR:                sel = 4'b1000;
            FN_OR:                 sel = 4'b1100;
            default:               sel = 4'b0000;
        endcase
        return sel;
    endfunction

    // Carry-in for the low nibble. Subtraction is computed as A + ~B + 1,
    // so SBC borrows by feeding the inverted carry flag.
    function automatic logic lo_ci(input logic [2:0] fn, input logic cin);
        logic ci;
        ci = 1'b0;
        case (fn)
            FN_ADC:        ci = cin;
            FN_SUB, FN_CP: ci = 1'b1;
            FN_SBC:        ci = ~cin;
            default:       ci = 1'b0;
        endcase
        return ci;
    endfunction

    logic is_add;
    logic is_sub;
    assign is_add = (fn_reg == FN_ADD) || (fn_reg == FN_ADC);
    assign is_sub = (fn_reg == FN_SUB) || (fn_reg == FN_SBC) || (fn_reg == FN_CP);

    assign alu_sh = NO_SH;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            fn_reg         <= 3'd0;
            a_reg          <= 8'd0;
            b_reg          <= 8'd0;
            cin_reg        <= 1'b0;
            hc_reg         <= 1'b0;
            sif.req_ready  <= 1'b1;
            sif.rsp_valid  <= 1'b0;
            sif.rsp_result <= 8'd0;
            sif.rsp_z      <= 1'b0;
            sif.rsp_n      <= 1'b0;
            sif.rsp_h      <= 1'b0;
            sif.rsp_c      <= 1'b0;
            alu_op         <= 8'd0;
            alu_oe         <= SH_OE;
            alu_la         <= NO_LD;
            alu_lb         <= NO_LD;
            alu_r          <= 1'b0;
            alu_s          <= 1'b0;
            alu_v          <= 1'b0;
            alu_ne         <= 1'b0;
            alu_ci         <= 1'b0;
            alu_l          <= 1'b0;
            alu_h          <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sif.req_valid && sif.req_ready) begin
                        fn_reg        <= sif.req_fn;
                        a_reg         <= sif.req_a;
                        b_reg         <= sif.req_b;
                        cin_reg       <= sif.req_cin;
                        sif.req_ready <= 1'b0;
                        alu_op        <= sif.req_a;
                        alu_la        <= BUS_LD;
                        state_reg     <= LDA;
                    end
                end

                LDA: begin
                    alu_op <= b_reg;
                    alu_la <= NO_LD;
                    alu_lb <= BUS_LD;
                    alu_l  <= 1'b1;
                    {alu_r, alu_s, alu_v, alu_ne} <= fsel(fn_reg);
                    alu_ci    <= lo_ci(fn_reg, cin_reg);
                    state_reg <= LO;
                end

                LO: begin
                    hc_reg    <= alu_carry;
                    alu_op    <= 8'd0;
                    alu_lb    <= NO_LD;
                    alu_l     <= 1'b0;
                    alu_h     <= 1'b1;
                    alu_ci    <= 1'b0;
                    alu_oe    <= RES_OE;
                    state_reg <= HI;
                end

                HI: begin
                    // CP only sets flags; the accumulator value passes through.
                    sif.rsp_result <= (fn_reg == FN_CP) ? a_reg : alu_result;
                    sif.rsp_z      <= alu_zero;
                    sif.rsp_n      <= is_sub;
                    sif.rsp_h      <= is_add ? hc_reg :
                                      is_sub ? ~hc_reg :
                                      (fn_reg == FN_AND);
                    sif.rsp_c      <= is_add ? alu_carry :
                                      is_sub ? ~alu_carry : 1'b0;
                    sif.rsp_valid  <= 1'b1;
                    alu_oe         <= SH_OE;
                    alu_h          <= 1'b0;
                    {alu_r, alu_s, alu_v, alu_ne} <= 4'b0000;
                    state_reg      <= DONE;
                end

                DONE: begin
                    if (NO_BACKPRESSURE || sif.rsp_ready) begin
                        sif.rsp_valid <= 1'b0;
                        sif.req_ready <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    sif.req_ready <= 1'b1;
                    sif.rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
